// File: rtl/dsram_responder_pkg.sv
// Shared types and sizing helpers for the data-SRAM bus responder.
package dsram_responder_pkg;

  // Access size codes carried on the bus; wstrb remains authoritative.
  typedef enum logic [1:0] {
    SramSizeB = 2'd0,
    SramSizeH = 2'd1,
    SramSizeW = 2'd2
  } sram_size_e;

  function automatic int unsigned timer_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

  // Response entry layout: {is_wr, data[31:0], timer}.
  function automatic int unsigned resp_len(input int unsigned lat);
    return 1 + 32 + timer_width(lat);
  endfunction

endpackage

// File: rtl/dsram_resp_fifo.sv
// In-order response queue; every entry carries its own latency countdown.
module dsram_resp_fifo
  import dsram_responder_pkg::*;
#(
  parameter int unsigned QDEPTH = 2,
  parameter int unsigned LAT    = 1
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_push,
  input  logic        i_push_is_wr,
  input  logic [31:0] i_push_data,
  input  logic        i_pop,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_head_ready,
  output logic        o_head_is_wr,
  output logic [31:0] o_head_data
);

  localparam int unsigned TW = timer_width(LAT);
  localparam int unsigned EW = resp_len(LAT);
  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned PW = $clog2(QDEPTH) + 1;
  localparam logic [PW-1:0] PTR_MASK   = PW'(QDEPTH - 1);
  localparam logic [TW-1:0] TIMER_INIT = TW'(LAT - 1);

  logic [EW-1:0] r_ent [QDEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic [EW-1:0] w_head;

  assign w_wr_idx = AW'(r_wr_ptr & PTR_MASK);
  assign w_rd_idx = AW'(r_rd_ptr & PTR_MASK);

  // Full when the pointers differ only in the wrap bit.
  assign o_full  = (r_wr_ptr ^ r_rd_ptr) == PW'(QDEPTH);
  assign o_empty = (r_wr_ptr == r_rd_ptr);

  assign w_head       = r_ent[w_rd_idx];
  assign o_head_ready = !o_empty && (w_head[TW-1:0] == '0);
  assign o_head_is_wr = w_head[EW-1];
  assign o_head_data  = w_head[TW +: 32];

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Timers run independently of queue position; idle slots are overwritten on push.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < QDEPTH; i++) begin
      if (i_push && (w_wr_idx == AW'(i))) begin
        r_ent[i] <= {i_push_is_wr, i_push_data, TIMER_INIT};
      end else if (r_ent[i][TW-1:0] != '0) begin
        r_ent[i][TW-1:0] <= r_ent[i][TW-1:0] - TW'(1);
      end
    end
  end

endmodule

// File: rtl/dsram_responder.sv
// Memory-side responder for the req/addr_ok/data_ok data bus, backed by an on-chip word array
// with configurable latency and in-order outstanding requests.
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LAT        = 1,
  parameter int unsigned QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  logic [31:0] r_mem [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_accept;
  logic [31:0]           w_rd_word;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_head_ready;
  logic                  w_head_is_wr;
  logic [31:0]           w_head_data;
  logic                  w_unused;

  // Upper address bits are dropped, so the array aliases across the address space.
  assign w_idx     = addr[DEPTH_LOG2+1:2];
  assign w_accept  = req && addr_ok;
  assign w_rd_word = r_mem[w_idx];
  assign w_unused  = ^{size, addr[31:DEPTH_LOG2+2], addr[1:0], w_empty};

  assign addr_ok = !w_full;
  assign data_ok = w_head_ready;
  assign rdata   = (w_head_ready && !w_head_is_wr) ? w_head_data : 32'h0;

  always_ff @(posedge clk) begin
    if (w_accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  dsram_resp_fifo #(
    .QDEPTH (QDEPTH),
    .LAT    (LAT)
  ) u_fifo (
    .i_clk        (clk),
    .i_resetn     (resetn),
    .i_push       (w_accept),
    .i_push_is_wr (wr),
    .i_push_data  (wr ? 32'h0 : w_rd_word),
    .i_pop        (w_head_ready),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_head_ready (w_head_ready),
    .o_head_is_wr (w_head_is_wr),
    .o_head_data  (w_head_data)
  );

endmodule

// File: tb/tb_dsram_responder.sv
// Three responders (LAT/QDEPTH = 1/2, 4/2, 3/4) share one stimulus stream and are checked each
// cycle against a transaction-level model: responses due at accept+LAT, in order, one per cycle.
module tb_dsram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        aok [3];
  logic        dok [3];
  logic [31:0] rd  [3];

  always #5 clk = ~clk;

  dsram_responder #(.DEPTH_LOG2(10), .LAT(1), .QDEPTH(2)) u_dut_a (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rd[0])
  );
  dsram_responder #(.DEPTH_LOG2(10), .LAT(4), .QDEPTH(2)) u_dut_b (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rd[1])
  );
  dsram_responder #(.DEPTH_LOG2(10), .LAT(3), .QDEPTH(4)) u_dut_c (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .addr_ok(aok[2]), .data_ok(dok[2]), .rdata(rd[2])
  );

  typedef struct {
    int          k;
    int unsigned due;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          cnt [3];
  logic [31:0] mm [3][1024];
  int unsigned cyc;
  int          errors;
  int          checks;
  logic        o_aok [3];
  logic        o_dok [3];
  logic [31:0] o_rd  [3];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 3;
  endfunction

  function automatic int qd_of(input int k);
    return (k == 2) ? 4 : 2;
  endfunction

  function automatic int head_of(input int k);
    for (int i = 0; i < mq.size(); i++) if (mq[i].k == k) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    req = r; wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2;
  endtask

  // One bus cycle: compare all outputs mid-cycle, then advance the model at the clock edge.
  task automatic step();
    logic        e_aok [3];
    logic        e_dok [3];
    logic [31:0] e_rd  [3];
    int          h;
    int          idx;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      h        = head_of(k);
      e_aok[k] = (cnt[k] < qd_of(k));
      e_dok[k] = (h >= 0) && (mq[h].due <= cyc);
      e_rd[k]  = e_dok[k] ? mq[h].d : 32'h0;
      o_aok[k] = aok[k];
      o_dok[k] = dok[k];
      o_rd[k]  = rd[k];
      chk($sformatf("addr_ok[%0d]@%0d", k, cyc), {31'h0, o_aok[k]}, {31'h0, e_aok[k]});
      chk($sformatf("data_ok[%0d]@%0d", k, cyc), {31'h0, o_dok[k]}, {31'h0, e_dok[k]});
      chk($sformatf("rdata[%0d]@%0d", k, cyc), o_rd[k], e_rd[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (e_dok[k]) begin
        mq.delete(head_of(k));
        cnt[k]--;
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (req && e_aok[k]) begin
        idx = int'((addr >> 2) & 32'h3FF);
        if (wr) begin
          for (int b = 0; b < 4; b++) if (wstrb[b]) mm[k][idx][8*b +: 8] = wdata[8*b +: 8];
        end
        mq.push_back('{k: k, due: cyc + lat_of(k), d: wr ? 32'h0 : mm[k][idx]});
        cnt[k]++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [31:0] words [3];

  initial begin
    errors = 0; checks = 0; cyc = 0;
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    resetn = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_dok[%0d]", k), {31'h0, dok[k]}, 32'h0);
      chk($sformatf("reset_rdata[%0d]", k), rd[k], 32'h0);
    end
    #10 resetn = 1'b1;
    @(posedge clk); #1;
    idle(2);

    // Write then read with LAT=1.
    drive(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF); step();
    drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);        step();
    chk("raw_wr_resp_dok", {31'h0, o_dok[0]}, 32'h1);
    chk("raw_wr_resp_rdata", o_rd[0], 32'h0);
    idle(1);
    chk("raw_rd_resp_dok", {31'h0, o_dok[0]}, 32'h1);
    chk("raw_rd_resp_rdata", o_rd[0], 32'hDEADBEEF);
    idle(8);

    // Byte strobe merge.
    drive(1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344); step();
    idle(5);
    drive(1'b1, 1'b1, 32'h20, 4'b0100, 32'h00AA0000); step();
    idle(5);
    drive(1'b1, 1'b0, 32'h20, 4'h0, 32'h0); step();
    idle(1);
    chk("strobe_merge", o_rd[0], 32'h11AA3344);
    idle(8);

    // Back-pressure on LAT=4, QDEPTH=2.
    drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    for (int s = 0; s < 6; s++) begin
      step();
      if (s < 2)  chk($sformatf("bp_aok_s%0d", s), {31'h0, o_aok[1]}, 32'h1);
      if (s == 2) chk("bp_full_aok", {31'h0, o_aok[1]}, 32'h0);
      if (s == 3) chk("bp_no_dok_yet", {31'h0, o_dok[1]}, 32'h0);
      if (s == 4) begin
        chk("bp_first_dok", {31'h0, o_dok[1]}, 32'h1);
        chk("bp_full_pop_aok", {31'h0, o_aok[1]}, 32'h0);
      end
      if (s == 5) begin
        chk("bp_second_dok", {31'h0, o_dok[1]}, 32'h1);
        chk("bp_aok_back", {31'h0, o_aok[1]}, 32'h1);
      end
    end
    idle(12);

    // Aliasing of upper address bits.
    drive(1'b1, 1'b1, 32'h1000_0000, 4'hF, 32'hCAFEF00D); step();
    idle(5);
    drive(1'b1, 1'b0, 32'h0000_0000, 4'h0, 32'h0); step();
    idle(1);
    chk("alias_rdata", o_rd[0], 32'hCAFEF00D);
    idle(8);

    // Ordering with LAT=3.
    words[0] = 32'hA1A1_0001; words[1] = 32'hB2B2_0002; words[2] = 32'hC3C3_0003;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h40 + 32'(4 * i), 4'hF, words[i]); step();
      idle(5);
    end
    for (int s = 0; s < 6; s++) begin
      if (s < 3) drive(1'b1, 1'b0, 32'h40 + 32'(4 * s), 4'h0, 32'h0);
      else       drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      step();
      if (s == 2) chk("order_no_early_dok", {31'h0, o_dok[2]}, 32'h0);
      if (s >= 3) begin
        chk($sformatf("order_dok_%0d", s - 3), {31'h0, o_dok[2]}, 32'h1);
        chk($sformatf("order_rdata_%0d", s - 3), o_rd[2], words[s-3]);
      end
    end
    idle(8);

    // Reset mid-operation with two writes outstanding on the LAT=4 responder.
    drive(1'b1, 1'b1, 32'h80, 4'hF, 32'h5555AAAA); step();
    drive(1'b1, 1'b1, 32'h84, 4'hF, 32'h3C3C_C3C3); step();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #3 resetn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst_dok[%0d]", k), {31'h0, dok[k]}, 32'h0);
      chk($sformatf("midrst_rdata[%0d]", k), rd[k], 32'h0);
    end
    mq.delete();
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    idle(6);
    drive(1'b1, 1'b0, 32'h80, 4'h0, 32'h0); step();
    idle(1);
    chk("persist_after_reset", o_rd[0], 32'h5555AAAA);
    idle(6);

    // Preload a pool of words, then random traffic with aliased addresses.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 32'(('h100 + i) << 2), 4'hF, $urandom); step();
      idle(4);
    end
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            ($urandom & 32'hFFFF_F000) | 32'(('h100 + $urandom_range(0, 15)) << 2) |
            ($urandom & 32'h3),
            4'($urandom), $urandom);
      step();
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
